// File: rtl/alu_1bit.sv
// alu_1bit: single-bit ALU slice (XNOR / NOR / ADD / SUB) with registered s, cout and out_valid.
// Optional macro ALU_1BIT_STICKY_EN adds sticky_clr / sticky_cout (sticky OR of registered cout).
module alu_1bit #(
  parameter logic RESET_S    = 1'b0,
  parameter logic RESET_COUT = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic [1:0] op,
`ifdef ALU_1BIT_STICKY_EN
  input  logic       sticky_clr,
  output logic       sticky_cout,
`endif
  output logic       s,
  output logic       cout,
  output logic       out_valid
);

  // Handshake: valid-only. a/b/cin/op are taken on any rising edge with in_valid=1, and the
  // result appears with out_valid=1 for exactly one cycle after that edge. There is no ready.

  typedef enum logic [1:0] {
    OP_XNOR = 2'b00,
    OP_NOR  = 2'b01,
    OP_ADD  = 2'b10,
    OP_SUB  = 2'b11
  } op_e;

  op_e  op_sel;
  logic b_eff;
  logic s_next;
  logic cout_next;

  assign op_sel = op_e'(op);

  // SUB is a + ~b + cin, so it shares the full-adder path with an inverted b.
  always_comb begin
    s_next    = 1'b0;
    cout_next = 1'b0;
    b_eff     = b;
    case (op_sel)
      OP_XNOR: s_next = ~(a ^ b);
      OP_NOR:  s_next = ~(a | b);
      OP_ADD: begin
        s_next    = a ^ b_eff ^ cin;
        cout_next = (a & b_eff) | (a & cin) | (b_eff & cin);
      end
      OP_SUB: begin
        b_eff     = ~b;
        s_next    = a ^ b_eff ^ cin;
        cout_next = (a & b_eff) | (a & cin) | (b_eff & cin);
      end
      default: begin
        s_next    = 1'b0;
        cout_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s         <= RESET_S;
      cout      <= RESET_COUT;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        s    <= s_next;
        cout <= cout_next;
      end
    end
  end

`ifdef ALU_1BIT_STICKY_EN
  // Clear wins over a simultaneous set so software never loses a clear request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_cout <= 1'b0;
    end else if (sticky_clr) begin
      sticky_cout <= 1'b0;
    end else if (in_valid && cout_next) begin
      sticky_cout <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_1bit.sv
// tb_alu_1bit: scoreboard bench for alu_1bit; expected {s,cout} queued at drive time, popped when out_valid.
// Sticky checks are compiled in when ALU_1BIT_STICKY_EN is defined.
module tb_alu_1bit;

  localparam logic RESET_S    = 1'b0;
  localparam logic RESET_COUT = 1'b0;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       a;
  logic       b;
  logic       cin;
  logic [1:0] op;
  logic       s;
  logic       cout;
  logic       out_valid;
  logic       sticky_clr;
`ifdef ALU_1BIT_STICKY_EN
  logic       sticky_cout;
`endif

  int checks   = 0;
  int failures = 0;

  logic [1:0] exp_q[$];
  logic       last_s   = RESET_S;
  logic       last_c   = RESET_COUT;
  logic       exp_stk  = 1'b0;

  alu_1bit #(
    .RESET_S   (RESET_S),
    .RESET_COUT(RESET_COUT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .a          (a),
    .b          (b),
    .cin        (cin),
    .op         (op),
`ifdef ALU_1BIT_STICKY_EN
    .sticky_clr (sticky_clr),
    .sticky_cout(sticky_cout),
`endif
    .s          (s),
    .cout       (cout),
    .out_valid  (out_valid)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%b exp=%b", tag, obs, exp);
    end
  endtask

  // Reference model, written straight from the operation table: returns {s, cout}.
  function automatic logic [1:0] model(input logic [1:0] o, input logic x, input logic y, input logic c);
    logic ny;
    ny = ~y;
    case (o)
      2'b00:   return {~(x ^ y), 1'b0};
      2'b01:   return {~(x | y), 1'b0};
      2'b10:   return {x ^ y ^ c, (x & y) | (x & c) | (y & c)};
      default: return {x ^ ny ^ c, (x & ny) | (x & c) | (ny & c)};
    endcase
  endfunction

  // driver tasks
  task automatic drive(input logic [1:0] o, input logic x, input logic y, input logic c, input logic clr);
    @(negedge clk);
    in_valid   = 1'b1;
    op         = o;
    a          = x;
    b          = y;
    cin        = c;
    sticky_clr = clr;
    exp_q.push_back(model(o, x, y, c));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid   = 1'b0;
      sticky_clr = 1'b0;
      op         = 2'($urandom_range(0, 3));
      a          = 1'($urandom_range(0, 1));
      b          = 1'($urandom_range(0, 1));
      cin        = 1'($urandom_range(0, 1));
    end
  endtask

  // monitor / scoreboard: one process owns the output model
  always @(posedge clk or negedge rst_n) begin
    logic       smp;
    logic       smp_clr;
    logic [1:0] e;
    if (!rst_n) begin
      last_s  = RESET_S;
      last_c  = RESET_COUT;
      exp_stk = 1'b0;
    end else begin
      smp     = in_valid;
      smp_clr = sticky_clr;
      e       = {last_s, last_c};
      #1;
      check("out_valid", {1'b0, out_valid}, {1'b0, smp});
      if (smp) begin
        if (exp_q.size() == 0) begin
          check("queue_underflow", 2'd1, 2'd0);
        end else begin
          e = exp_q.pop_front();
          check("result", {s, cout}, e);
        end
        last_s = e[1];
        last_c = e[0];
      end else begin
        check("hold", {s, cout}, e);
      end
      if (smp_clr) exp_stk = 1'b0;
      else if (smp && e[0]) exp_stk = 1'b1;
`ifdef ALU_1BIT_STICKY_EN
      check("sticky", {1'b0, sticky_cout}, {1'b0, exp_stk});
`endif
    end
  end

  initial begin
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    a          = 1'b0;
    b          = 1'b0;
    cin        = 1'b0;
    op         = 2'b00;
    sticky_clr = 1'b0;

    // reset held with toggling inputs
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'($urandom_range(0, 1));
      op       = 2'($urandom_range(0, 3));
      a        = 1'($urandom_range(0, 1));
      b        = 1'($urandom_range(0, 1));
      cin      = 1'($urandom_range(0, 1));
      #1;
      check("reset_out", {s, cout}, {RESET_S, RESET_COUT});
      check("reset_vld", {1'b0, out_valid}, 2'b00);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    idle(2);

    // SUB sequence
    drive(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(2'b11, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(1);

    // ADD exhaustive, back-to-back
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      drive(2'b10, v[2], v[1], v[0], 1'b0);
    end
    idle(1);

    // logic ops with cin=1
    for (int o = 0; o < 2; o++) begin
      for (int i = 0; i < 4; i++) begin
        logic [1:0] v;
        v = 2'(i);
        drive(2'(o), v[1], v[0], 1'b1, 1'b0);
      end
    end

    // random mix
    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      else drive(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'b0);
    end

    // sticky behaviour (ports only exist in the feature build; set/clear still modelled)
    drive(2'b10, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(2'b01, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(2'b10, 1'b1, 1'b1, 1'b1, 1'b1);
    drive(2'b00, 1'b0, 1'b1, 1'b0, 1'b0);

    // hold then async reset between edges, with s/cout left at 1/1
    drive(2'b10, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(3);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_out", {s, cout}, {RESET_S, RESET_COUT});
    check("async_reset_vld", {1'b0, out_valid}, 2'b00);
    exp_q.delete();
    #1;
    rst_n = 1'b1;
    idle(2);

    // reset while an op is in flight: it must be discarded
    drive(2'b10, 1'b1, 1'b1, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    check("inflight_discard", {s, cout}, {RESET_S, RESET_COUT});
    check("inflight_vld", {1'b0, out_valid}, 2'b00);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    idle(2);
    drive(2'b11, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(2);

    // drain with a bounded wait
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    check("drain", 2'(exp_q.size() != 0), 2'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_1bit.md
Name: alu_1bit

Overview:
- Single-bit ALU slice with registered outputs, intended as the building block of wider ripple ALUs.
- Four operations, selected by a 2-bit op code: XNOR, NOR, ADD and SUB. The carry/borrow chain goes through cin/cout.
- One clock domain. Results are registered one cycle after a valid input is sampled.

Parameters:
- RESET_S, 1'b0, reset value of s.
- RESET_COUT, 1'b0, reset value of cout.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  a, b, cin and op are sampled on this clk edge when high
- a  input  1  operand A
- b  input  1  operand B
- cin  input  1  carry-in (ADD) / inverted-borrow-in (SUB); ignored for logic ops
- op  input  2  operation select
- s  output  1  registered result bit
- cout  output  1  registered carry-out
- out_valid  output  1  high for exactly one cycle after each sampled in_valid
- sticky_clr  input  1  clears sticky_cout; present only with ALU_1BIT_STICKY_EN
- sticky_cout  output  1  sticky OR of cout; present only with ALU_1BIT_STICKY_EN

Behaviour:
- Reset: rst_n low forces the outputs immediately, independent of clk.
  - s=RESET_S, cout=RESET_COUT, out_valid=0.
  - sticky_cout=0 (feature build).
  - Deassertion is synchronised by the environment. The first sampling edge is the first rising clk with rst_n high.
- Operation is computed combinationally from the inputs and registered on rising clk when in_valid=1:
  - op=2'b00 XNOR: s = ~(a ^ b); cout = 0.
  - op=2'b01 NOR: s = ~(a | b); cout = 0.
  - op=2'b10 ADD: s = a ^ b ^ cin; cout = (a&b) | (a&cin) | (b&cin).
  - op=2'b11 SUB (a + ~b + cin): bb = ~b; s = a ^ bb ^ cin; cout = (a&bb) | (a&cin) | (bb&cin).
  - SUB: cin=1 at the LSB gives two's-complement a-b. cout=1 means no borrow.
- Latency: exactly 1 clk from the sampling edge to s/cout/out_valid.
- in_valid=0 on an edge: s and cout hold their previous values; out_valid=0 on the next cycle.
- Back-to-back in_valid: a new result every cycle; out_valid stays high continuously. No backpressure exists.
- All op codes are defined; there is no illegal-op case.
- Reset mid-operation: any in-flight result is discarded and outputs return to reset values.

Optional Feature:
- Macro: ALU_1BIT_STICKY_EN.
- Defined:
  - sticky_clr and sticky_cout ports exist.
  - On each rising clk: if sticky_clr=1, sticky_cout becomes 0. Otherwise, if in_valid=1 and the newly computed cout=1, sticky_cout becomes 1. Otherwise it holds.
  - sticky_clr has priority over a simultaneous set.
  - sticky_cout updates on the same edge as cout.
- Not defined: the ports are absent, and s, cout and out_valid behave identically.

Test Plan:
- Reset: rst_n=0 with toggling inputs, then release -> s=0, cout=0, out_valid=0, stable until the first in_valid edge.
- SUB: op=11, a=0, b=0, cin=0 sampled -> next cycle s=1, cout=0, out_valid=1. Then op=11, a=0, b=1, cin=0 -> s=0, cout=0. Then op=11, a=0, b=0, cin=0 -> s=1, cout=0.
- ADD exhaustive: op=10, all 8 (a,b,cin) combinations back-to-back -> each s/cout matches the full-adder table one cycle later; out_valid held high for 8 cycles. For example a=1, b=1, cin=1 gives s=1, cout=1.
- Logic ops: op=00 and op=01 over all (a,b) with cin=1 -> XNOR gives 1,0,0,1; NOR gives 1,0,0,0; cout=0 throughout.
- Hold/async reset: in_valid=0 for 3 cycles -> s/cout unchanged, out_valid=0. Then pulse rst_n low between clk edges -> outputs reset without waiting for clk.
- Sticky (ALU_1BIT_STICKY_EN):
  - op=10, a=1, b=1 -> sticky_cout=1.
  - Stays 1 through later cout=0 results.
  - sticky_clr=1 together with a cout=1 op -> sticky_cout=0.
